sram_sync_dp_clr: RTL and testbench



---
 rtl/sram_sync_dp_clr.sv | 159 +++++++++++++++
 tb/tb_sram_sync_dp_clr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sync_dp_clr.sv
// Dual-port sync RAM: port A read/write with byte lanes, port B read-only, built-in clear sequencer.
// Latency: reads 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); writes land on the sampling edge.
// Backpressure: none; port A writes arriving while busy are dropped, reads are always served.
module sram_sync_dp_clr #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    LANES          = 1,
  parameter int                    RDW_MODE       = 0,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [DATA_WIDTH-1:0] DATA_A,
  input  logic [LANES-1:0]      BE_A,
  input  logic                  cen_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] Q_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  input  logic                  cen_b,
  output logic [DATA_WIDTH-1:0] Q_B
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    wr_a;
  logic                    clr_we;
  logic [DATA_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_b;
  logic [DATA_WIDTH-1:0]   q1_a;
  logic [DATA_WIDTH-1:0]   q1_b;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Replace the lanes selected by be with the corresponding bytes of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Port A owns the array only while the clear engine is idle.
  assign wr_a   = cen_a & we_a & ~busy;
  // Hold the clear engine off the array while reset is asserted.
  assign clr_we = busy & ~rst;

  // Clear sequencer: sweep every address once, then return to idle; clr while busy is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy  <= (CLEAR_ON_RESET != 0);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_WIDTH{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write: clear engine and port A are mutually exclusive through busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= CLEAR_VALUE;
    end else if (wr_a) begin
      mem[ADDR_A] <= merge(mem[ADDR_A], DATA_A, BE_A);
    end
  end

  // Port A read word, optionally forwarding its own same-cycle write.
  always_comb begin
    rd_a = mem[ADDR_A];
    if ((RDW_MODE != 0) && wr_a) begin
      rd_a = merge(mem[ADDR_A], DATA_A, BE_A);
    end
  end

  // Port B read word, optionally forwarding a same-address port A write (clear writes never forward).
  always_comb begin
    rd_b = mem[ADDR_B];
    if ((RDW_MODE != 0) && wr_a && (ADDR_A == ADDR_B)) begin
      rd_b = merge(mem[ADDR_B], DATA_A, BE_A);
    end
  end

  // First read stage: loads only on an enabled read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_a <= '0;
      q1_b <= '0;
    end else begin
      if (cen_a) q1_a <= rd_a;
      if (cen_b) q1_b <= rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  ld1_a;
      logic                  ld1_b;
      logic [DATA_WIDTH-1:0] q2_a;
      logic [DATA_WIDTH-1:0] q2_b;

      // Output stage follows the first stage one cycle later, only for words that were actually read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ld1_a <= 1'b0;
          ld1_b <= 1'b0;
          q2_a  <= '0;
          q2_b  <= '0;
        end else begin
          ld1_a <= cen_a;
          ld1_b <= cen_b;
          if (ld1_a) q2_a <= q1_a;
          if (ld1_b) q2_b <= q1_b;
        end
      end

      assign Q_A = q2_a;
      assign Q_B = q2_b;
    end else begin : g_noreg
      assign Q_A = q1_a;
      assign Q_B = q1_b;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sync_dp_clr.sv
// Bench for sram_sync_dp_clr: two instances covering both read-during-write modes and both output options.
// u0: 16-bit, 2 lanes, new-data RDW, no output register, clear on reset to A5A5.
// u1: 8-bit, 1 lane, old-data RDW, output register, no clear on reset, clear value 5A.
module tb_sram_sync_dp_clr;

  typedef struct packed {
    logic [15:0] v;
    logic        chk;
  } exp_t;

  typedef struct {
    string       nm;
    logic [15:0] act;
    logic [15:0] exp;
  } dreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clr0, busy0, cen_a0, we_a0, cen_b0;
  logic [3:0]  addr_a0, addr_b0;
  logic [15:0] data_a0, q_a0, q_b0;
  logic [1:0]  be_a0;

  logic        clr1, busy1, cen_a1, we_a1, cen_b1;
  logic [3:0]  addr_a1, addr_b1;
  logic [7:0]  data_a1, q_a1, q_b1;
  logic [0:0]  be_a1;

  exp_t  q0a[$], q0b[$], q1a[$], q1b[$];
  dreq_t dq[$];
  exp_t  l0a, l0b, l1a, l1b;
  logic  v0a, v0b, v1a1, v1a2, v1b1, v1b2;
  int    n_chk = 0;
  int    n_err = 0;
  int    n;

  always #5 clk = ~clk;

  sram_sync_dp_clr #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .LANES(2), .RDW_MODE(1), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)
  ) u0 (
    .clk(clk), .rst(rst), .clr(clr0), .busy(busy0),
    .ADDR_A(addr_a0), .DATA_A(data_a0), .BE_A(be_a0), .cen_a(cen_a0), .we_a(we_a0), .Q_A(q_a0),
    .ADDR_B(addr_b0), .cen_b(cen_b0), .Q_B(q_b0)
  );

  sram_sync_dp_clr #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .LANES(1), .RDW_MODE(0), .OUT_REG(1),
    .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h5A)
  ) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .busy(busy1),
    .ADDR_A(addr_a1), .DATA_A(data_a1), .BE_A(be_a1), .cen_a(cen_a1), .we_a(we_a1), .Q_A(q_a1),
    .ADDR_B(addr_b1), .cen_b(cen_b1), .Q_B(q_b1)
  );

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic underflow(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: output presented with no expected entry queued", nm);
  endtask

  // Read-issue pipeline, mirrors the documented latency (1 cycle for u0, 2 cycles for u1).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v0a <= 1'b0; v0b <= 1'b0; v1a1 <= 1'b0; v1a2 <= 1'b0; v1b1 <= 1'b0; v1b2 <= 1'b0;
    end else begin
      v0a  <= cen_a0;
      v0b  <= cen_b0;
      v1a1 <= cen_a1;
      v1a2 <= v1a1;
      v1b1 <= cen_b1;
      v1b2 <= v1b1;
    end
  end

  // Monitor: compares outputs against the scoreboard when a read completes, checks hold otherwise.
  always @(negedge clk) begin
    exp_t  e;
    dreq_t d;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      check(d.nm, d.act, d.exp);
    end
    if (rst) begin
      l0a = '{v: 16'h0, chk: 1'b1};
      l0b = '{v: 16'h0, chk: 1'b1};
      l1a = '{v: 16'h0, chk: 1'b1};
      l1b = '{v: 16'h0, chk: 1'b1};
    end else begin
      if (v0a) begin
        if (q0a.size() == 0) underflow("u0_qa");
        else begin e = q0a.pop_front(); if (e.chk) check("u0_qa", q_a0, e.v); l0a = e; end
      end else if (l0a.chk) check("u0_qa_hold", q_a0, l0a.v);

      if (v0b) begin
        if (q0b.size() == 0) underflow("u0_qb");
        else begin e = q0b.pop_front(); if (e.chk) check("u0_qb", q_b0, e.v); l0b = e; end
      end else if (l0b.chk) check("u0_qb_hold", q_b0, l0b.v);

      if (v1a2) begin
        if (q1a.size() == 0) underflow("u1_qa");
        else begin e = q1a.pop_front(); if (e.chk) check("u1_qa", {8'h00, q_a1}, e.v); l1a = e; end
      end else if (l1a.chk) check("u1_qa_hold", {8'h00, q_a1}, l1a.v);

      if (v1b2) begin
        if (q1b.size() == 0) underflow("u1_qb");
        else begin e = q1b.pop_front(); if (e.chk) check("u1_qb", {8'h00, q_b1}, e.v); l1b = e; end
      end else if (l1b.chk) check("u1_qb_hold", {8'h00, q_b1}, l1b.v);
    end
  end

  // ---------------- stimulus ----------------
  task automatic dchk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    dreq_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic set_a0(input logic we, input logic [3:0] a, input logic [15:0] dat,
                        input logic [1:0] be, input logic [15:0] ev, input logic chk);
    exp_t e;
    cen_a0 = 1'b1; we_a0 = we; addr_a0 = a; data_a0 = dat; be_a0 = be;
    e.v = ev; e.chk = chk;
    q0a.push_back(e);
  endtask

  task automatic set_b0(input logic [3:0] a, input logic [15:0] ev);
    exp_t e;
    cen_b0 = 1'b1; addr_b0 = a;
    e.v = ev; e.chk = 1'b1;
    q0b.push_back(e);
  endtask

  task automatic set_a1(input logic we, input logic [3:0] a, input logic [7:0] dat, input logic [7:0] ev);
    exp_t e;
    cen_a1 = 1'b1; we_a1 = we; addr_a1 = a; data_a1 = dat; be_a1 = 1'b1;
    e.v = {8'h00, ev}; e.chk = 1'b1;
    q1a.push_back(e);
  endtask

  task automatic set_b1(input logic [3:0] a, input logic [7:0] ev);
    exp_t e;
    cen_b1 = 1'b1; addr_b1 = a;
    e.v = {8'h00, ev}; e.chk = 1'b1;
    q1b.push_back(e);
  endtask

  // Advance one cycle (inputs changed on the falling edge) and idle all controls.
  task automatic step();
    @(negedge clk);
    cen_a0 = 1'b0; we_a0 = 1'b0; cen_b0 = 1'b0; clr0 = 1'b0;
    cen_a1 = 1'b0; we_a1 = 1'b0; cen_b1 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr0 = 0; cen_a0 = 0; we_a0 = 0; cen_b0 = 0; addr_a0 = 0; addr_b0 = 0; data_a0 = 0; be_a0 = 0;
    clr1 = 0; cen_a1 = 0; we_a1 = 0; cen_b1 = 0; addr_a1 = 0; addr_b1 = 0; data_a1 = 0; be_a1 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    dchk("rst_busy0", {15'h0, busy0}, 16'h1);
    dchk("rst_busy1", {15'h0, busy1}, 16'h0);
    dchk("rst_qa0", q_a0, 16'h0);
    dchk("rst_qb0", q_b0, 16'h0);
    dchk("rst_qa1", {8'h0, q_a1}, 16'h0);
    dchk("rst_qb1", {8'h0, q_b1}, 16'h0);
    rst = 1'b0;

    // u0 clear after reset: dropped write to 15, ignored clr, read of an already-cleared word
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 3) set_a0(1'b1, 4'd15, 16'hFFFF, 2'b11, 16'h0000, 1'b0);
      if (n == 5) clr0 = 1'b1;
      if (n == 8) set_b0(4'd0, 16'hA5A5);
      step();
      n++;
    end
    dchk("u0_busy_len", 16'(n), 16'd16);

    for (int i = 0; i < 16; i++) begin
      set_b0(4'(i), 16'hA5A5);
      step();
    end

    // u0 byte lanes with new-data read-during-write
    set_a0(1'b1, 4'd3, 16'h1234, 2'b11, 16'h1234, 1'b1); step();
    set_a0(1'b1, 4'd3, 16'hABCD, 2'b10, 16'hAB34, 1'b1); step();
    set_a0(1'b1, 4'd3, 16'hFFFF, 2'b00, 16'hAB34, 1'b1); step();
    set_a0(1'b0, 4'd3, 16'h0000, 2'b00, 16'hAB34, 1'b1); step();
    step();
    set_a0(1'b1, 4'd7, 16'h0055, 2'b11, 16'h0055, 1'b1); set_b0(4'd7, 16'h0055); step();
    set_b0(4'd7, 16'h0055); step();
    set_a0(1'b1, 4'd8, 16'h1111, 2'b11, 16'h1111, 1'b1); set_b0(4'd9, 16'hA5A5); step();
    step();

    // u1 explicit clear, clr repeated mid-clear must not extend it
    clr1 = 1'b1;
    step();
    n = 0;
    while (busy1 && n < 100) begin
      if (n == 4) clr1 = 1'b1;
      step();
      n++;
    end
    dchk("u1_busy_len", 16'(n), 16'd16);

    // u1 old-data read-during-write on both ports
    set_a1(1'b1, 4'd7, 8'h55, 8'h5A); set_b1(4'd7, 8'h5A); step();
    set_b1(4'd7, 8'h55); set_a1(1'b0, 4'd7, 8'h00, 8'h55); step();
    repeat (3) step();

    // u1 output register: 2-cycle latency then hold
    set_a1(1'b1, 4'd2, 8'h3C, 8'h5A); step();
    set_a1(1'b0, 4'd2, 8'h00, 8'h3C); step();
    repeat (4) step();

    // u1 clr together with a write in idle: write happens, then the clear overwrites it
    set_a1(1'b1, 4'd2, 8'h99, 8'h3C); clr1 = 1'b1; step();
    n = 0;
    while (busy1 && n < 100) begin
      step();
      n++;
    end
    dchk("u1_busy_len2", 16'(n), 16'd16);
    set_a1(1'b0, 4'd2, 8'h00, 8'h5A); step();
    repeat (3) step();

    // reset in the middle of a clear on both instances
    clr0 = 1'b1; clr1 = 1'b1; step();
    repeat (5) step();
    #1 rst = 1'b1;
    #1;
    dchk("midrst_qa0", q_a0, 16'h0);
    dchk("midrst_qb0", q_b0, 16'h0);
    dchk("midrst_qa1", {8'h0, q_a1}, 16'h0);
    dchk("midrst_qb1", {8'h0, q_b1}, 16'h0);
    dchk("midrst_busy0", {15'h0, busy0}, 16'h1);
    dchk("midrst_busy1", {15'h0, busy1}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      step();
      n++;
    end
    dchk("u0_busy_len2", 16'(n), 16'd16);
    dchk("u1_idle_after_rst", {15'h0, busy1}, 16'h0);
    set_b0(4'd8, 16'hA5A5); set_a0(1'b0, 4'd3, 16'h0000, 2'b00, 16'hA5A5, 1'b1); step();
    set_b1(4'd2, 8'h5A); step();
    repeat (3) step();

    dchk("u0_qa_left", 16'(q0a.size()), 16'd0);
    dchk("u0_qb_left", 16'(q0b.size()), 16'd0);
    dchk("u1_qa_left", 16'(q1a.size()), 16'd0);
    dchk("u1_qb_left", 16'(q1b.size()), 16'd0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
